// File: rtl/alu_pkg.sv
// ALU control codes, opcode legality check and the arbiter FSM state type
// shared by the ALU arbiter files.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOP: is_legal_op = 1'b1;
      default:                                             is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_grant.sv
// Round-robin priority picker: one-hot grant to the first asserted request
// found scanning upward from ptr_i, wrapping modulo NREQ.
module rr_grant #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_i} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_i[idx[PW-1:0]]) begin
        grant_o[idx[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// one operation in flight, registered ALU drive and registered result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic [W-1:0]      alu_in1,
  output logic [W-1:0]      alu_in2,
  output logic [3:0]        alu_ctrl,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_zero
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      state_q;
  logic [PW-1:0]   rr_ptr_q, owner_q, gnt_idx, ptr_next;
  logic [NREQ-1:0] grant, rsp_valid_q;
  logic [W-1:0]    alu_in1_q, alu_in2_q, rsp_result_q;
  logic [3:0]      alu_ctrl_q, sel_op;
  logic            rsp_zero_q, accept;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic [3:0]      op_arr[NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a[gi*W +: W];
    assign b_arr[gi]  = req_b[gi*W +: W];
    assign op_arr[gi] = req_op[gi*4 +: 4];
  end

  rr_grant #(.NREQ(NREQ), .PW(PW)) u_rr_grant (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_op    = op_arr[gnt_idx];
  assign ptr_next  = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gnt_idx = PW'(i);
    end
  end

  // ALU pins come only from these registers, so req_* never reaches alu_* combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_ctrl_q   <= ALU_NOP;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_in1_q  <= a_arr[gnt_idx];
            alu_in2_q  <= b_arr[gnt_idx];
            alu_ctrl_q <= is_legal_op(sel_op) ? sel_op : ALU_NOP;
            owner_q    <= gnt_idx;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_out;
          rsp_zero_q   <= alu_zero;
          alu_in1_q    <= '0;
          alu_in2_q    <= '0;
          alu_ctrl_q   <= ALU_NOP;
          rsp_valid_q  <= NREQ'(1) << owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            rr_ptr_q    <= ptr_next;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_ctrl   = alu_ctrl_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [W*NREQ-1:0] req_a = '0;
  logic [W*NREQ-1:0] req_b = '0;
  logic [4*NREQ-1:0] req_op = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero;
  logic [W-1:0]      alu_in1, alu_in2, alu_out;
  logic [3:0]        alu_ctrl;
  logic              alu_zero;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Environment ALU; undefined codes return a^b so an unlegalised code is visible.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_out = alu_in1 & alu_in2;
      4'b0001: alu_out = alu_in1 | alu_in2;
      4'b0010: alu_out = alu_in1 + alu_in2;
      4'b0110: alu_out = alu_in1 - alu_in2;
      4'b0111: alu_out = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      4'b1111: alu_out = '0;
      default: alu_out = alu_in1 ^ alu_in2;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] legal(input logic [3:0] op);
    if (op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111}) return op;
    return 4'b1111;
  endfunction

  // Transaction model: phase 0 = waiting for a grant, 1 = ALU cycle, 2 = response pending.
  int          m_phase = 0, m_ptr = 0, m_owner = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_ctrl = 4'hF;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy, e_rv;
    int g;
    g = pick(req_valid, m_ptr);
    e_rdy = '0;
    e_rv  = '0;
    if (m_phase == 0 && g >= 0) e_rdy[g] = 1'b1;
    if (m_phase == 2) e_rv[m_owner] = 1'b1;
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("alu_ctrl", 32'(alu_ctrl), (m_phase == 1) ? 32'(m_ctrl) : 32'hF);
      chk("alu_in1", alu_in1, (m_phase == 1) ? m_a : 32'd0);
      chk("alu_in2", alu_in2, (m_phase == 1) ? m_b : 32'd0);
      if (m_phase == 2) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
      end
    end
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_owner = 0;
    end else if (m_phase == 0) begin
      if (g >= 0) begin
        m_a     = req_a[g*W +: W];
        m_b     = req_b[g*W +: W];
        m_ctrl  = legal(req_op[g*4 +: 4]);
        m_res   = ref_alu(m_a, m_b, req_op[g*4 +: 4]);
        m_owner = g;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rsp_ready[m_owner]) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_phase = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_valid[i]      = v;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
    req_op[i*4 +: 4]  = op;
  endtask

  // Single-requester op from IDLE with rsp_ready high; literal expectations supplied by caller.
  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] e_ctrl,
                       input logic [31:0] e_res, input logic e_zero);
    set_req(i, 1'b1, a, b, op);
    settle();
    chk("lit_grant", 32'(req_ready), 32'(1) << i);
    step();
    set_req(i, 1'b0, 32'd0, 32'd0, 4'd0);
    settle();
    chk("lit_exec_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
    chk("lit_exec_rv", 32'(rsp_valid), 32'd0);
    step();
    settle();
    chk("lit_rsp_valid", 32'(rsp_valid), 32'(1) << i);
    chk("lit_result", rsp_result, e_res);
    chk("lit_zero", 32'(rsp_zero), 32'(e_zero));
    step();
    settle();
    chk("lit_rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  logic [NREQ-1:0] last_acc;
  logic [3:0] ops[8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF, 4'h3, 4'hC};

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_en = 1;
    settle();
    chk("lit_rst_rv", 32'(rsp_valid), 32'd0);
    chk("lit_rst_ctrl", 32'(alu_ctrl), 32'hF);
    chk("lit_rst_res", rsp_result, 32'd0);
    chk("lit_rst_zero", 32'(rsp_zero), 32'd0);
    rsp_ready = 2'b11;

    step();
    do_op(0, 32'd5, 32'd7, 4'b0010, 4'b0010, 32'd12, 1'b0);
    do_op(1, 32'd9, 32'd9, 4'b0110, 4'b0110, 32'd0, 1'b1);
    do_op(1, 32'd3, 32'd4, 4'b0111, 4'b0111, 32'd1, 1'b0);

    // Stalled response for req0 while req1 waits; pointer is 0 here.
    rsp_ready = 2'b10;
    set_req(0, 1'b1, 32'hF0, 32'h0F, 4'b0001);
    set_req(1, 1'b1, 32'd2, 32'd3, 4'b0010);
    settle();
    chk("lit_stall_grant", 32'(req_ready), 32'b01);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    for (int n = 0; n < 5; n++) begin
      settle();
      chk("lit_stall_rv", 32'(rsp_valid), 32'b01);
      chk("lit_stall_res", rsp_result, 32'hFF);
      chk("lit_stall_rdy", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    step();
    settle();
    chk("lit_req1_grant", 32'(req_ready), 32'b10);
    step();
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    settle();
    chk("lit_req1_rv", 32'(rsp_valid), 32'b10);
    chk("lit_req1_res", rsp_result, 32'd5);
    step();

    // Both valid continuously: grants alternate starting from requester 0.
    set_req(0, 1'b1, 32'd10, 32'd20, 4'b0010);
    set_req(1, 1'b1, 32'd50, 32'd8, 4'b0110);
    for (int n = 0; n < 4; n++) begin
      settle();
      chk("lit_alt_grant", 32'(req_ready), (n % 2 == 0) ? 32'b01 : 32'b10);
      step(); step();
      settle();
      chk("lit_alt_rv", 32'(rsp_valid), (n % 2 == 0) ? 32'b01 : 32'b10);
      chk("lit_alt_res", rsp_result, (n % 2 == 0) ? 32'd30 : 32'd42);
      step();
    end
    req_valid = '0;
    step();

    do_op(0, 32'd1, 32'd1, 4'b0011, 4'b1111, 32'd0, 1'b1);

    // Reset during EXEC with pointer at 1; afterwards pointer must be back at 0.
    set_req(0, 1'b1, 32'd1, 32'd2, 4'b0010);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst = 1'b1;
    settle();
    chk("lit_rst_exec_ctrl", 32'(alu_ctrl), 32'b0010);
    step();
    rst = 1'b0;
    settle();
    chk("lit_rst2_rv", 32'(rsp_valid), 32'd0);
    chk("lit_rst2_ctrl", 32'(alu_ctrl), 32'hF);
    step(); step();
    settle();
    chk("lit_rst2_norsp", 32'(rsp_valid), 32'd0);
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0010);
    set_req(1, 1'b1, 32'd7, 32'd7, 4'b0000);
    settle();
    chk("lit_rst2_ptr", 32'(req_ready), 32'b01);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    settle();
    chk("lit_rst2_rv", 32'(rsp_valid), 32'b01);
    chk("lit_rst2_res", rsp_result, 32'd2);
    step();

    // Randomized traffic against the model.
    last_acc = '0;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !last_acc[i]) begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(9) < 4) begin
          logic [31:0] a, b;
          a = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(15));
          b = ($urandom_range(3) == 0) ? a : (($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(15)));
          set_req(i, 1'b1, a, b, ops[$urandom_range(7)]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(3) != 0);
      rst = ($urandom_range(299) == 0);
      settle();
      last_acc = rst ? '0 : (req_valid & req_ready);
    end
    rst = 1'b0;
    req_valid = '0;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the EX stage and a branch-compare unit.
- Each requester issues an operation over a valid/ready request channel and gets its result back over a valid/ready response channel.
- Requesters are granted round-robin. One operation is in flight at a time.
- The block owns the ALU input/control pins and registers the ALU result and zero flag.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept; at most one bit high.
- req_a  in  W*NREQ  packed operand 1; slice i belongs to requester i.
- req_b  in  W*NREQ  packed operand 2.
- req_op  in  4*NREQ  packed ALU control code.
- rsp_valid  out  NREQ  one-hot response valid, to the owning requester.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_result  out  W  registered ALU result; shared bus, qualified by rsp_valid.
- rsp_zero  out  1  registered ALU zero flag.
- alu_in1  out  W  to ALU input1.
- alu_in2  out  W  to ALU input2.
- alu_ctrl  out  4  to ALU control.
- alu_out  in  W  from ALU out.
- alu_zero  in  1  from ALU Zero.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst high at a clk edge):
  - state=IDLE, rr_ptr=0, owner=0.
  - Operand/op/result registers cleared to 0.
  - rsp_valid=0, rsp_result=0, rsp_zero=0.
  - alu_in1=alu_in2=0, alu_ctrl=NOP (4'b1111).
  - An in-flight transaction is dropped with no response.
  - rst has priority over every other event.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot on g, combinational from req_valid and rr_ptr; all zero if no valid.
  - On req_valid[g] && req_ready[g]: capture req_a[g], req_b[g] and req_op[g] into registers, set owner=g, go to EXEC.
  - req_ready is zero in every state other than IDLE.
- Opcode legalisation at capture:
  - Legal codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOP 1111.
  - Any other code is stored as NOP, which yields result 0 and zero 1.
- EXEC (one cycle):
  - alu_in1/alu_in2/alu_ctrl driven from the captured registers.
  - At the cycle end, alu_out → rsp_result and alu_zero → rsp_zero; go to RESP.
- RESP:
  - rsp_valid[owner]=1; result and zero held stable.
  - alu_ctrl=NOP, alu inputs=0.
  - Wait for rsp_ready[owner].
  - On handshake: rr_ptr=(owner+1) mod NREQ, go to IDLE.
  - rsp_ready of non-owners is ignored.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid high from cycle T+1 (first cycle in RESP).
  - Minimum 3 cycles per operation; no overlap between RESP and a new accept.
- The ALU is driven only from registers, so no combinational path runs from req_* to alu_*.
- Requester obligations:
  - Must hold valid and payload until accepted.
  - Deasserting valid before acceptance is legal; no grant is issued.
- Simultaneous requests: only the granted one is accepted; the others stay pending.

Decomposition:
- Package alu_pkg holds:
  - ALU control localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOP.
  - An is_legal_op function.
  - FSM state encoding: IDLE, EXEC, RESP.
- Natural sub-module: rr_grant (NREQ-wide round-robin priority picker).
  - Inputs: req vector, pointer.
  - Output: one-hot grant.

Test Plan:
- Req0 ADD a=5, b=7, rsp_ready=1 → req_ready[0] at T; rsp_valid=01, rsp_result=12, rsp_zero=0 one cycle after acceptance (cycle T+1).
- Req1 SUB a=9, b=9 → rsp_valid=10, rsp_result=0, rsp_zero=1; then SLT a=3, b=4 → result 1, zero 0.
- req_valid=11 held continuously, rsp_ready=11 → grants alternate 0,1,0,1; results return to the matching rsp_valid bit each time.
- Req0 OR 0xF0|0x0F with rsp_ready[0]=0 for 5 cycles while req1 valid → rsp_result=0xFF stable, req_ready=00 throughout, and rsp_ready[1]=1 has no effect; req1 is granted after the req0 handshake.
- Illegal op 4'b0011 with a=1, b=1 → alu_ctrl observed as 1111 in EXEC, rsp_result=0, rsp_zero=1.
- rst asserted during EXEC → next cycle IDLE, rsp_valid=00, alu_ctrl=1111, rr_ptr=0; no response for the dropped op; a new req0 ADD 1+1 returns 2.
